// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
//   state_t  - FSM state encodings (IF/ID/EX/MEM/WB; codes 5-7 unused)
//   IDX_*    - bit positions of the instructions the controller treats specially
//   iclass_t - instruction class flags produced by mc_instr_class
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam int IDX_JR  = 16;
  localparam int IDX_LW  = 22;
  localparam int IDX_SW  = 23;
  localparam int IDX_BEQ = 24;
  localparam int IDX_BNE = 25;
  localparam int IDX_J   = 29;
  localparam int IDX_JAL = 30;

  typedef struct packed {
    logic is_br;
    logic is_jmp;   // j, jr and jal
    logic is_ld;
    logic is_st;
    logic is_link;  // jal writes the return address
    logic legal;    // exactly one bit of i set
  } iclass_t;

endpackage

// File: rtl/mc_instr_class.sv
// mc_instr_class: combinational decode of the one-hot instruction vector.
//   i   - one-hot decoded instruction
//   cls - class flags; legal is low for zero or multiple bits set
module mc_instr_class
  import mc_pkg::*;
(
  input  logic [31:0] i,
  output iclass_t     cls
);

  always_comb begin
    cls         = '0;
    cls.is_br   = i[IDX_BEQ] | i[IDX_BNE];
    cls.is_jmp  = i[IDX_J] | i[IDX_JR] | i[IDX_JAL];
    cls.is_ld   = i[IDX_LW];
    cls.is_st   = i[IDX_SW];
    cls.is_link = i[IDX_JAL];
    cls.legal   = $onehot(i);
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle CPU control FSM with a retired-instruction counter.
//   clk, rst        - clock, synchronous active-high reset
//   i               - one-hot decoded instruction (valid from ID on)
//   zero            - ALU zero flag (valid in EX)
//   mem_rdy         - shared memory port ready
//   mem_req, dm_r, dm_w - memory request and data read/write qualifiers
//   ir_w, pc_w, pc_br, rf_w - datapath strobes
//   state           - current FSM state
//   illegal         - one-cycle pulse on a non-one-hot instruction in ID
//   retired         - completed instruction count (wraps)
// Strobes are decoded from the current state and inputs in the same cycle,
// since ir_w and the MEM exit must react to mem_rdy without a cycle of delay.
module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        mem_req,
  output logic        dm_r,
  output logic        dm_w,
  output logic        ir_w,
  output logic        pc_w,
  output logic        pc_br,
  output logic        rf_w,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t     st, nxt;
  logic [31:0] retired_q;
  iclass_t    ic;

  mc_instr_class u_cls (.i(i), .cls(ic));

  // Outputs are forced low while rst is high so an in-flight operation is
  // dropped without a PC/RF write or memory access.
  always_comb begin
    nxt     = S_IF;
    mem_req = 1'b0;
    dm_r    = 1'b0;
    dm_w    = 1'b0;
    ir_w    = 1'b0;
    pc_w    = 1'b0;
    pc_br   = 1'b0;
    rf_w    = 1'b0;
    illegal = 1'b0;
    case (st)
      S_IF: begin
        mem_req = ~rst;
        ir_w    = ~rst & mem_rdy;
        nxt     = mem_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        if (!ic.legal) begin
          illegal = ~rst;
          pc_w    = ~rst;
          nxt     = S_IF;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (ic.is_br) begin
          pc_w  = ~rst;
          pc_br = ~rst & ((i[IDX_BEQ] & zero) | (i[IDX_BNE] & ~zero));
          nxt   = S_IF;
        end else if (ic.is_jmp) begin
          pc_w = ~rst;
          rf_w = ~rst & ic.is_link;
          nxt  = S_IF;
        end else if (ic.is_ld || ic.is_st) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = ~rst;
        dm_r    = ~rst & i[IDX_LW];
        dm_w    = ~rst & i[IDX_SW];
        if (!mem_rdy)       nxt = S_MEM;
        else if (ic.is_ld)  nxt = S_WB;
        else begin
          pc_w = ~rst;
          nxt  = S_IF;
        end
      end
      S_WB: begin
        rf_w = ~rst;
        pc_w = ~rst;
        nxt  = S_IF;
      end
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IF;
      retired_q <= '0;
    end else begin
      st <= nxt;
      // Only the illegal-instruction PC bump in ID fails to retire.
      if (pc_w && !illegal) retired_q <= retired_q + 32'd1;
    end
  end

  assign state   = st;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i;
  logic        zero, mem_rdy;
  logic        mem_req, dm_r, dm_w, ir_w, pc_w, pc_br, rf_w, illegal;
  logic [2:0]  state;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] I_ADD = 32'h0000_0001;
  localparam logic [31:0] I_LW  = 32'h0040_0000;
  localparam logic [31:0] I_SW  = 32'h0080_0000;
  localparam logic [31:0] I_BEQ = 32'h0100_0000;
  localparam logic [31:0] I_JAL = 32'h4000_0000;
  localparam logic [31:0] I_BAD = 32'h00C0_0000;

  mc_controller dut (
    .clk(clk), .rst(rst), .i(i), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .dm_r(dm_r), .dm_w(dm_w), .ir_w(ir_w),
    .pc_w(pc_w), .pc_br(pc_br), .rf_w(rf_w), .state(state),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs mid-cycle, let combinational outputs settle, then check.
  task automatic cyc(input logic r, input logic [31:0] ii, input logic z, input logic rdy);
    @(negedge clk);
    rst = r; i = ii; zero = z; mem_rdy = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; i = '0; zero = 1'b0; mem_rdy = 1'b0;
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_irw", ir_w, 0);

    // IF waits on mem_rdy
    cyc(0, I_ADD, 0, 0);
    chk("if_wait_memreq", mem_req, 1);
    chk("if_wait_irw", ir_w, 0);
    cyc(0, I_ADD, 0, 0);
    chk("if_wait_state", state, 0);

    // ALU: IF, ID, EX, WB
    cyc(0, I_ADD, 0, 1);
    chk("alu_if_irw", ir_w, 1);
    cyc(0, I_ADD, 0, 1);
    chk("alu_id_state", state, 1);
    chk("alu_id_pcw", pc_w, 0);
    cyc(0, I_ADD, 0, 1);
    chk("alu_ex_state", state, 2);
    cyc(0, I_ADD, 0, 1);
    chk("alu_wb_state", state, 4);
    chk("alu_wb_rfw", rf_w, 1);
    chk("alu_wb_pcw", pc_w, 1);
    chk("alu_wb_ret0", retired, 0);
    cyc(0, I_BEQ, 1, 1);
    chk("alu_ret1", retired, 1);
    chk("alu_back_if", state, 0);

    // beq taken
    cyc(0, I_BEQ, 1, 1);
    cyc(0, I_BEQ, 1, 1);
    chk("beq_t_state", state, 2);
    chk("beq_t_pcw", pc_w, 1);
    chk("beq_t_pcbr", pc_br, 1);
    chk("beq_t_rfw", rf_w, 0);
    // beq not taken
    cyc(0, I_BEQ, 0, 1);
    chk("beq_n_state", state, 0);
    chk("beq_ret2", retired, 2);
    cyc(0, I_BEQ, 0, 1);
    cyc(0, I_BEQ, 0, 1);
    chk("beq_n_pcw", pc_w, 1);
    chk("beq_n_pcbr", pc_br, 0);
    chk("beq_n_rfw", rf_w, 0);

    // lw with 3 wait cycles in MEM: 8 cycles total
    cyc(0, I_LW, 0, 1);
    chk("lw_ret3", retired, 3);
    cyc(0, I_LW, 0, 0);   // ID: mem_rdy ignored
    chk("lw_id_state", state, 1);
    cyc(0, I_LW, 0, 0);
    chk("lw_ex_state", state, 2);
    for (int k = 0; k < 4; k++) begin
      cyc(0, I_LW, 0, (k == 3));
      chk("lw_mem_state", state, 3);
      chk("lw_mem_req", mem_req, 1);
      chk("lw_mem_dmr", dm_r, 1);
      chk("lw_mem_dmw", dm_w, 0);
      chk("lw_mem_pcw", pc_w, 0);
    end
    cyc(0, I_LW, 0, 1);
    chk("lw_wb_state", state, 4);
    chk("lw_wb_rfw", rf_w, 1);
    chk("lw_wb_pcw", pc_w, 1);

    // two-bit instruction -> illegal in ID
    cyc(0, I_BAD, 0, 1);
    chk("ill_if_ret4", retired, 4);
    cyc(0, I_BAD, 0, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_pcw", pc_w, 1);
    chk("ill_pcbr", pc_br, 0);
    cyc(0, I_BAD, 0, 0);
    chk("ill_next_if", state, 0);
    chk("ill_pulse_end", illegal, 0);
    chk("ill_ret_same", retired, 4);

    // jal: link written in EX
    cyc(0, I_JAL, 0, 1);
    cyc(0, I_JAL, 0, 1);
    cyc(0, I_JAL, 0, 1);
    chk("jal_pcw", pc_w, 1);
    chk("jal_rfw", rf_w, 1);
    chk("jal_pcbr", pc_br, 0);

    // sw, reset while stalled in MEM
    cyc(0, I_SW, 0, 1);
    chk("sw_ret5", retired, 5);
    cyc(0, I_SW, 0, 1);
    cyc(0, I_SW, 0, 1);
    cyc(0, I_SW, 0, 0);
    chk("sw_mem_dmw", dm_w, 1);
    chk("sw_mem_dmr", dm_r, 0);
    cyc(1, I_SW, 0, 1);
    chk("sw_rst_pcw", pc_w, 0);
    cyc(0, I_SW, 0, 0);
    chk("sw_rst_state", state, 0);
    chk("sw_rst_dmw", dm_w, 0);
    chk("sw_rst_pcw2", pc_w, 0);
    chk("sw_rst_ret", retired, 0);

    // wrap: preload all-ones, retire one ALU instruction
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    cyc(0, I_ADD, 0, 1);
    cyc(0, I_ADD, 0, 1);
    cyc(0, I_ADD, 0, 1);
    cyc(0, I_ADD, 0, 1);
    chk("wrap_pre", retired, 32'hFFFF_FFFF);
    cyc(0, I_ADD, 0, 0);
    chk("wrap_zero", retired, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset: clk and rst (rst sampled only on rising clk).
REQ-002 Port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port i, input, 32, one-hot decoded instruction in the existing 31-instruction encoding, valid from ID onward (i[22]=lw, i[23]=sw, i[24]=beq, i[25]=bne, i[29]=j, i[30]=jal, i[16]=jr).
REQ-005 Port zero, input, 1, ALU result-equals-zero flag, valid in EX.
REQ-006 Port mem_rdy, input, 1, shared memory port done/ready for current request.
REQ-007 Port mem_req, output, 1, memory request (fetch or data).
REQ-008 Port dm_r / dm_w, output, 1 each, data read / write qualifier for mem_req.
REQ-009 Port ir_w, output, 1, instruction register load strobe.
REQ-010 Port pc_w, output, 1, PC update strobe.
REQ-011 Port pc_br, output, 1, PC select branch target (valid with pc_w).
REQ-012 Port rf_w, output, 1, register file write strobe.
REQ-013 Port state, output, 3, current FSM state encoding.
REQ-014 Port illegal, output, 1, one-cycle pulse on non-one-hot i in ID.
REQ-015 Port retired, output, 32, count of completed instructions.

Function
REQ-016 States SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 unreachable, and if entered SHALL go to IF next cycle.
REQ-017 IF: mem_req=1, dm_r=dm_w=0; stay while mem_rdy=0; on mem_rdy=1 pulse ir_w for that cycle, go ID.
REQ-018 ID: one cycle; if i has zero or more than one bit set, pulse illegal, pulse pc_w (pc_br=0, sequential), go IF, no retire; else go EX.
REQ-019 EX, branch (i[24]/i[25]): pc_w=1, pc_br=(i[24]&zero)|(i[25]&~zero), go IF.
REQ-020 EX, jump (i[29]/i[16]): pc_w=1, pc_br=0 (datapath muxes select target), go IF; jal (i[30]): also rf_w=1 same cycle.
REQ-021 EX, lw/sw: go MEM; all other instructions: go WB.
REQ-022 MEM: mem_req=1, dm_r=i[22], dm_w=i[23], held stable until mem_rdy=1; on mem_rdy: lw -> WB; sw -> pc_w=1, go IF.
REQ-023 WB: rf_w=1, pc_w=1 (pc_br=0), go IF; one cycle.
REQ-024 Every cycle with pc_w=1 and legal instruction SHALL increment retired, wrapping 0xFFFFFFFF -> 0.
REQ-025 Outputs rf_w, dm_w, pc_w, ir_w SHALL never assert outside states listed above; dm_r and dm_w never both 1.
REQ-026 Latencies with mem_rdy tied 1: ALU 4 cycles, branch/jump 3, lw 5, sw 4.
REQ-027 mem_rdy outside IF/MEM SHALL be ignored.

Reset
REQ-028 On rst=1: state=IF, retired=0, all strobes and illegal 0 in the following cycle; mem_req asserts first cycle after rst deasserts.
REQ-029 rst mid-operation (any state, including pending mem_req) SHALL abandon it without pc_w, rf_w or retire.

Structure
REQ-030 Package mc_pkg SHALL hold state encodings and instruction index constants (IDX_LW=22, IDX_SW=23, IDX_BEQ=24, IDX_BNE=25, IDX_JR=16, IDX_J=29, IDX_JAL=30).
REQ-031 One combinational sub-module mc_instr_class SHALL map i to {is_br, is_jmp, is_ld, is_st, is_link, legal}; FSM and counter stay in mc_controller.

Verification
REQ-032 Add-class i=1<<0, mem_rdy=1 -> states IF,ID,EX,WB; rf_w and pc_w in cycle 4; retired 0->1.
REQ-033 beq i=1<<24, zero=1 -> EX pc_w=1,pc_br=1; zero=0 -> pc_br=0; rf_w never 1.
REQ-034 lw with mem_rdy low 3 cycles in MEM -> mem_req=1,dm_r=1 held 4 cycles, then WB rf_w=1; total 8 cycles.
REQ-035 i=0x00C00000 (two bits) in ID -> illegal=1 one cycle, pc_w=1, retired unchanged, next state IF.
REQ-036 rst asserted in MEM of sw -> next cycle state=IF, dm_w=0, pc_w=0, retired=0.
REQ-037 retired preloaded via 2^32-1 retires (forced) then one more -> retired=0.
